// File: rtl/pong_pkg.sv
// Shared constants for the Pong match sequencer: state encodings, winner codes
// and serve directions.
package pong_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SERVE = 3'd1;
   localparam logic [2:0] ST_PLAY  = 3'd2;
   localparam logic [2:0] ST_POINT = 3'd3;
   localparam logic [2:0] ST_OVER  = 3'd4;

   localparam logic [1:0] WINNER_NONE = 2'b00;
   localparam logic [1:0] WINNER_P1   = 2'b01;
   localparam logic [1:0] WINNER_P2   = 2'b10;

   localparam logic SERVE_TO_P1 = 1'b0;
   localparam logic SERVE_TO_P2 = 1'b1;

   typedef logic [3:0] score_t;

endpackage

// File: rtl/pong_if.sv
// Game-event inputs and match-status outputs of the match sequencer, grouped as
// one bundle; the sequencer takes the slave side.
interface pong_if;
   import pong_pkg::*;

   logic       frame_tick;
   logic       start;
   logic       goal_p1;
   logic       goal_p2;
   score_t     player1_score_unit;
   score_t     player2_score_unit;
   logic       ball_rst;
   logic       ball_en;
   logic       serve_dir;
   logic [1:0] winner;
   logic [2:0] state_dbg;

   modport master (
      output frame_tick, start, goal_p1, goal_p2,
      input  player1_score_unit, player2_score_unit, ball_rst, ball_en,
             serve_dir, winner, state_dbg
   );

   modport slave (
      input  frame_tick, start, goal_p1, goal_p2,
      output player1_score_unit, player2_score_unit, ball_rst, ball_en,
             serve_dir, winner, state_dbg
   );
endinterface

// File: rtl/rise_detect.sv
// One-bit rising-edge detector: a level held high yields a single-cycle pulse.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);
   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise = din & ~prev_q;
endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: score registers, serve/point delays and game-over flow,
// driven by edge-detected start and goal events.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 90,
   parameter int POINT_FRAMES = 45,
   parameter int CNT_W        = 8
) (
   input  logic  clk,
   input  logic  reset,
   pong_if.slave bus
);
   localparam logic [CNT_W-1:0] SERVE_CNT = CNT_W'(SERVE_FRAMES);
   localparam logic [CNT_W-1:0] POINT_CNT = CNT_W'(POINT_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam score_t           WIN_M1    = 4'(WIN_SCORE - 1);

   logic [2:0] ev_in;
   logic [2:0] ev_rise;
   logic       start_rise;
   logic       g1_rise;
   logic       g2_rise;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   score_t           p1_q, p1_d;
   score_t           p2_q, p2_d;
   logic [1:0]       winner_q, winner_d;
   logic             dir_q, dir_d;

   assign ev_in = {bus.goal_p2, bus.goal_p1, bus.start};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_edge
         rise_detect u_rise (
            .clk   (clk),
            .reset (reset),
            .din   (ev_in[gi]),
            .rise  (ev_rise[gi])
         );
      end
   endgenerate

   assign start_rise = ev_rise[0];
   assign g1_rise    = ev_rise[1];
   assign g2_rise    = ev_rise[2];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      p1_d     = p1_q;
      p2_d     = p2_q;
      winner_d = winner_q;
      dir_d    = dir_q;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start_rise) begin
               state_d  = ST_SERVE;
               cnt_d    = SERVE_CNT;
               p1_d     = '0;
               p2_d     = '0;
               winner_d = WINNER_NONE;
               dir_d    = SERVE_TO_P1;
            end
         end
         ST_SERVE: begin
            if (bus.frame_tick) begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = ST_PLAY;
               end
            end
         end
         ST_PLAY: begin
            // Simultaneous goals are a replay: no score, direction kept.
            if (g1_rise && g2_rise) begin
               state_d = ST_POINT;
               cnt_d   = POINT_CNT;
            end else if (g1_rise) begin
               p1_d  = p1_q + 4'd1;
               dir_d = SERVE_TO_P2;
               if (p1_q == WIN_M1) begin
                  state_d  = ST_OVER;
                  winner_d = WINNER_P1;
               end else begin
                  state_d = ST_POINT;
                  cnt_d   = POINT_CNT;
               end
            end else if (g2_rise) begin
               p2_d  = p2_q + 4'd1;
               dir_d = SERVE_TO_P1;
               if (p2_q == WIN_M1) begin
                  state_d  = ST_OVER;
                  winner_d = WINNER_P2;
               end else begin
                  state_d = ST_POINT;
                  cnt_d   = POINT_CNT;
               end
            end
         end
         ST_POINT: begin
            if (bus.frame_tick) begin
               if (cnt_q == CNT_ONE) begin
                  state_d = ST_SERVE;
                  cnt_d   = SERVE_CNT;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         p1_q     <= '0;
         p2_q     <= '0;
         winner_q <= WINNER_NONE;
         dir_q    <= SERVE_TO_P1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         winner_q <= winner_d;
         dir_q    <= dir_d;
      end
   end

   // Ball controls are pure state decodes so no input reaches an output.
   assign bus.ball_rst           = (state_q == ST_IDLE) || (state_q == ST_SERVE) ||
                                   (state_q == ST_OVER);
   assign bus.ball_en            = (state_q == ST_PLAY);
   assign bus.player1_score_unit = p1_q;
   assign bus.player2_score_unit = p2_q;
   assign bus.winner             = winner_q;
   assign bus.serve_dir          = dir_q;
   assign bus.state_dbg          = state_q;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Randomized bench for pong_match_ctrl: a match-level model predicts every
// cycle's outputs into a queue that an independent monitor compares.
module tb_pong_match_ctrl;
   localparam int WIN = 9;
   localparam int SF  = 90;
   localparam int PF  = 45;

   localparam int P_IDLE  = 0;
   localparam int P_SERVE = 1;
   localparam int P_PLAY  = 2;
   localparam int P_POINT = 3;
   localparam int P_OVER  = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pong_if bus();

   pong_match_ctrl #(
      .WIN_SCORE    (WIN),
      .SERVE_FRAMES (SF),
      .POINT_FRAMES (PF),
      .CNT_W        (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int idx;
      int st;
      int s1;
      int s2;
      int win;
      int brst;
      int ben;
      int dir;
   } exp_t;

   exp_t q[$];
   int cyc = 0;
   int errors = 0;
   int checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Match model: phase, frames still to wait, scores, winner, serve side.
   int m_phase = P_IDLE;
   int m_left = 0;
   int m_p1 = 0;
   int m_p2 = 0;
   int m_win = 0;
   int m_dir = 0;
   bit m_ps = 0, m_pg1 = 0, m_pg2 = 0;

   task automatic model_step(input bit rst, input bit tick, input bit st,
                             input bit g1, input bit g2);
      bit rs, r1, r2;
      if (rst) begin
         m_phase = P_IDLE; m_left = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0;
         m_ps = 0; m_pg1 = 0; m_pg2 = 0;
         return;
      end
      rs = st && !m_ps;
      r1 = g1 && !m_pg1;
      r2 = g2 && !m_pg2;
      m_ps = st; m_pg1 = g1; m_pg2 = g2;
      if (m_phase == P_IDLE || m_phase == P_OVER) begin
         if (rs) begin
            m_phase = P_SERVE; m_left = SF; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0;
         end
      end else if (m_phase == P_SERVE || m_phase == P_POINT) begin
         if (tick) begin
            m_left--;
            if (m_left == 0) begin
               if (m_phase == P_SERVE) m_phase = P_PLAY;
               else begin m_phase = P_SERVE; m_left = SF; end
            end
         end
      end else if (r1 || r2) begin
         if (r1 && !r2) begin m_p1++; m_dir = 1; end
         if (r2 && !r1) begin m_p2++; m_dir = 0; end
         if (m_p1 == WIN) begin m_phase = P_OVER; m_win = 1; end
         else if (m_p2 == WIN) begin m_phase = P_OVER; m_win = 2; end
         else begin m_phase = P_POINT; m_left = PF; end
      end
   endtask

   task automatic drive(input bit rst, input bit tick, input bit st,
                        input bit g1, input bit g2);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst;
      bus.frame_tick = tick;
      bus.start = st;
      bus.goal_p1 = g1;
      bus.goal_p2 = g2;
      model_step(rst, tick, st, g1, g2);
      e.idx  = cyc + 1;
      e.st   = m_phase;
      e.s1   = m_p1;
      e.s2   = m_p2;
      e.win  = m_win;
      e.brst = (m_phase == P_IDLE || m_phase == P_SERVE || m_phase == P_OVER) ? 1 : 0;
      e.ben  = (m_phase == P_PLAY) ? 1 : 0;
      e.dir  = m_dir;
      q.push_back(e);
   endtask

   function automatic bit rtick();
      return $urandom_range(0, 3) != 0;
   endfunction

   function automatic bit rnoise();
      return $urandom_range(0, 5) == 0;
   endfunction

   task automatic quiet();
      drive(0, rtick(), 0, 0, 0);
   endtask

   task automatic run_until(input int ph, input bit noise_start);
      int n = 0;
      while (m_phase != ph && n < 1000) begin
         drive(0, rtick(), noise_start ? rnoise() : 1'b0, rnoise(), rnoise());
         n++;
      end
      checks++;
      if (m_phase != ph) begin
         errors++;
         $display("FAIL run_until: phase %0d after %0d cycles, required %0d", m_phase, n, ph);
      end
      quiet();
   endtask

   task automatic score_goal(input bit who);
      int k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) drive(0, rtick(), rnoise(), 0, 0);
      drive(0, rtick(), 0, !who, who);
      quiet();
   endtask

   task automatic chk(input string name, input int act, input int exp_v, input int c);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, c, act, exp_v);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         while (q.size() > 0 && q[0].idx < cyc) begin
            e = q.pop_front();
            chk("stale_expectation", cyc, e.idx, cyc);
         end
         if (q.size() > 0 && q[0].idx == cyc) begin
            e = q.pop_front();
            chk("state_dbg", int'(bus.state_dbg), e.st, cyc);
            chk("p1_score", int'(bus.player1_score_unit), e.s1, cyc);
            chk("p2_score", int'(bus.player2_score_unit), e.s2, cyc);
            chk("winner", int'(bus.winner), e.win, cyc);
            chk("ball_rst", int'(bus.ball_rst), e.brst, cyc);
            chk("ball_en", int'(bus.ball_en), e.ben, cyc);
            chk("serve_dir", int'(bus.serve_dir), e.dir, cyc);
         end
      end
   end

   initial begin : stimulus
      int guard;
      bus.frame_tick = 0;
      bus.start = 0;
      bus.goal_p1 = 0;
      bus.goal_p2 = 0;
      for (int i = 0; i < 3; i++) drive(1, rtick(), 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, rtick(), 0, rnoise(), rnoise());
      quiet();
      drive(0, rtick(), 1, 0, 0);
      run_until(P_PLAY, 1);

      // Held goal counts once.
      for (int i = 0; i < 5; i++) drive(0, rtick(), 0, 1, 0);
      quiet();
      run_until(P_SERVE, 0);
      run_until(P_PLAY, 1);

      // Simultaneous goals replay the point.
      drive(0, rtick(), 0, 1, 1);
      quiet();

      guard = 0;
      while (m_phase != P_OVER && guard < 40) begin
         run_until(P_SERVE, 0);
         run_until(P_PLAY, 1);
         score_goal((m_p1 < 4 && $urandom_range(0, 1) == 1) ? 1'b0 : 1'b1);
         guard++;
      end
      checks++;
      if (m_phase != P_OVER) begin
         errors++;
         $display("FAIL match_end: phase %0d, required %0d", m_phase, P_OVER);
      end

      for (int i = 0; i < 6; i++) drive(0, rtick(), 0, i[0], !i[0]);
      quiet();
      drive(0, rtick(), 1, 0, 0);
      quiet();

      guard = 0;
      while ((m_p1 < 4 || m_p2 < 3) && guard < 20) begin
         run_until(P_SERVE, 0);
         run_until(P_PLAY, 1);
         score_goal(m_p1 >= 4);
         guard++;
      end
      run_until(P_SERVE, 0);
      run_until(P_PLAY, 1);
      drive(0, rtick(), 0, 0, 0);
      drive(1, rtick(), 1, 1, 1);
      for (int i = 0; i < 4; i++) drive(0, rtick(), 0, 0, 0);

      repeat (3) @(posedge clk);
      #4;
      chk("queue_drained", q.size(), 0, cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
